// File: rtl/lut_mult_pkg.sv
// Shared types and constants for the LUT multiplier datapath.
//   state_e    : recoder FSM states
//   NIBW       : digit (nibble) width in bits
//   NEG_THRESH : nibble+carry at or above this value is a negative digit
//   ndig()     : number of radix-16 signed digits emitted for an operand width
package lut_mult_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam int unsigned NIBW       = 4;
  localparam int unsigned NEG_THRESH = 8;

  // One digit per nibble plus a final digit that absorbs the top carry.
  function automatic int unsigned ndig(input int unsigned width);
    return width / NIBW + 1;
  endfunction

endpackage

// File: rtl/digit_sel.sv
// Combinational digit selector for the radix-16 signed-digit recoder.
//   b_i     : operand being recoded
//   idx_i   : digit index
//   carry_i : carry into this digit
//   nib_o   : nibble idx of b_i, 0 at the final index
//   neg_o   : digit is negative (nibble + carry >= 8), never on the final digit
//   last_o  : idx_i is the final digit index
module digit_sel
  import lut_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned NDIG = ndig(WIDTH),
  localparam int unsigned IDXW = $clog2(NDIG)
) (
  input  logic [WIDTH-1:0] b_i,
  input  logic [IDXW-1:0]  idx_i,
  input  logic             carry_i,
  output logic [NIBW-1:0]  nib_o,
  output logic             neg_o,
  output logic             last_o
);

  // 5-bit sum so that F + 1 = 16 does not wrap to 0.
  logic [NIBW:0] sum;

  always_comb begin
    nib_o = '0;
    for (int unsigned k = 0; k < NDIG - 1; k++) begin
      if (idx_i == IDXW'(k)) begin
        nib_o = b_i[NIBW*k +: NIBW];
      end
    end
  end

  assign last_o = (idx_i == IDXW'(NDIG - 1));
  assign sum    = {1'b0, nib_o} + {{NIBW{1'b0}}, carry_i};
  assign neg_o  = !last_o && (sum >= (NIBW + 1)'(NEG_THRESH));

endmodule

// File: rtl/nibble_recoder.sv
// Sequential radix-16 signed-digit recoder. Accepts one unsigned operand per
// transaction and streams NDIG digit beats (nibble, carry-in, sign) to the
// incrementer / LUT stages.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_b is the operand
//   out_valid/out_ready : digit beat handshake
//   out_nib, out_incr   : raw nibble and carry-in for the incrementer
//   out_neg             : digit value (nib + incr - 16*neg) is negative
//   out_idx, out_last   : digit index and final-digit flag
module nibble_recoder
  import lut_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned NDIG = ndig(WIDTH),
  localparam int unsigned IDXW = $clog2(NDIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NIBW-1:0]  out_nib,
  output logic             out_incr,
  output logic             out_neg,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last
);

  state_e           state_q;
  logic [WIDTH-1:0] b_q;
  logic             out_valid_q;
  logic [NIBW-1:0]  out_nib_q;
  logic             out_incr_q;
  logic             out_neg_q;
  logic [IDXW-1:0]  out_idx_q;
  logic             out_last_q;

  // Inputs to the selector: digit 0 of the incoming operand while idle,
  // otherwise the digit after the one currently presented.
  logic [WIDTH-1:0] sel_b;
  logic [IDXW-1:0]  sel_idx;
  logic             sel_c;
  logic [NIBW-1:0]  sel_nib;
  logic             sel_neg;
  logic             sel_last;

  always_comb begin
    if (state_q == StIdle) begin
      sel_b   = in_b;
      sel_idx = '0;
      sel_c   = 1'b0;
    end else begin
      sel_b   = b_q;
      sel_idx = out_idx_q + IDXW'(1);
      // Carry out of the presented digit is its sign flag.
      sel_c   = out_neg_q;
    end
  end

  digit_sel #(
    .WIDTH (WIDTH)
  ) u_digit_sel (
    .b_i     (sel_b),
    .idx_i   (sel_idx),
    .carry_i (sel_c),
    .nib_o   (sel_nib),
    .neg_o   (sel_neg),
    .last_o  (sel_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_nib_q   <= '0;
      out_incr_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q     <= StRun;
            b_q         <= in_b;
            out_valid_q <= 1'b1;
            out_nib_q   <= sel_nib;
            out_incr_q  <= sel_c;
            out_neg_q   <= sel_neg;
            out_idx_q   <= sel_idx;
            out_last_q  <= sel_last;
          end
        end
        StRun: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= StIdle;
              b_q         <= '0;
              out_valid_q <= 1'b0;
              out_nib_q   <= '0;
              out_incr_q  <= 1'b0;
              out_neg_q   <= 1'b0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_nib_q  <= sel_nib;
              out_incr_q <= sel_c;
              out_neg_q  <= sel_neg;
              out_idx_q  <= sel_idx;
              out_last_q <= sel_last;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_nib   = out_nib_q;
  assign out_incr  = out_incr_q;
  assign out_neg   = out_neg_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_nibble_recoder.sv
module tb_nibble_recoder;

  typedef struct packed {
    logic [3:0] nib;
    logic       incr;
    logic       neg;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_nib;
  logic        out_incr;
  logic        out_neg;
  logic [2:0]  out_idx;
  logic        out_last;

  nibble_recoder #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_nib   (out_nib),
    .out_incr  (out_incr),
    .out_neg   (out_neg),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference digits from the signed-digit rule: each digit is nibble + carry,
  // made negative by borrowing 16 from the next digit when it reaches 8.
  beat_t gen_q[$];

  function automatic void gen(input logic [15:0] b);
    int c;
    int n;
    beat_t t;
    gen_q.delete();
    c = 0;
    for (int i = 0; i < 5; i++) begin
      n = (i < 4) ? int'((b >> (4 * i)) & 16'hF) : 0;
      t.nib  = n[3:0];
      t.incr = (c != 0);
      t.neg  = (i < 4) && (n + c >= 8);
      t.idx  = 3'(i);
      t.last = (i == 4);
      gen_q.push_back(t);
      c = t.neg ? 1 : 0;
    end
  endfunction

  function automatic int recon();
    int s = 0;
    for (int i = 0; i < gen_q.size(); i++) begin
      s += (int'(gen_q[i].nib) + int'(gen_q[i].incr) - 16 * int'(gen_q[i].neg)) * (1 << (4 * i));
    end
    return s;
  endfunction

  // Transaction-level model: idle/busy plus the queue of beats still owed.
  beat_t       exp_q[$];
  bit          m_busy = 1'b0;
  logic [15:0] m_op;
  int          acc;
  bit          run_cmp = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_op   = in_b;
        acc    = 0;
        gen(in_b);
        foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
      end
    end else if (out_ready && exp_q.size() > 0) begin
      if (exp_q[0].last) m_busy = 1'b0;
      void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("out_valid", 64'(out_valid), 64'(m_busy));
      chk("in_ready", 64'(in_ready), 64'(!m_busy));
      if (m_busy && exp_q.size() > 0) begin
        chk("beat{nib,incr,neg,idx,last}",
            64'({out_nib, out_incr, out_neg, out_idx, out_last}), 64'(exp_q[0]));
        if (out_ready) begin
          int d;
          d = int'(out_nib) + int'(out_incr) - 16 * int'(out_neg);
          if (out_last) chk("final_digit_range", 64'(d >= 0 && d <= 1), 64'(1));
          else          chk("digit_range", 64'(d >= -8 && d <= 7), 64'(1));
          acc += d * (1 << (4 * int'(out_idx)));
          if (out_last) chk("reconstruct", 64'(acc), 64'(m_op));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_b     = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
    step();
    in_valid = 1'b0;
    in_b     = 16'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (!m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 64'(0), 64'(1));
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_b      = '0;
    out_ready = 1'b1;

    // Pin the model with hand-computed digits.
    gen(16'h00F8);
    chk("pin_F8_d0", 64'(gen_q[0]), 64'({4'h8, 1'b0, 1'b1, 3'd0, 1'b0}));
    chk("pin_F8_d1", 64'(gen_q[1]), 64'({4'hF, 1'b1, 1'b1, 3'd1, 1'b0}));
    chk("pin_F8_d2", 64'(gen_q[2]), 64'({4'h0, 1'b1, 1'b0, 3'd2, 1'b0}));
    chk("pin_F8_d4", 64'(gen_q[4]), 64'({4'h0, 1'b0, 1'b0, 3'd4, 1'b1}));
    chk("pin_F8_sum", 64'(recon()), 64'(248));
    gen(16'hFFFF);
    chk("pin_FFFF_d0", 64'(gen_q[0]), 64'({4'hF, 1'b0, 1'b1, 3'd0, 1'b0}));
    chk("pin_FFFF_d3", 64'(gen_q[3]), 64'({4'hF, 1'b1, 1'b1, 3'd3, 1'b0}));
    chk("pin_FFFF_d4", 64'(gen_q[4]), 64'({4'h0, 1'b1, 1'b0, 3'd4, 1'b1}));
    chk("pin_FFFF_sum", 64'(recon()), 64'(65535));
    gen(16'h1234);
    chk("pin_1234_d0", 64'(gen_q[0]), 64'({4'h4, 1'b0, 1'b0, 3'd0, 1'b0}));
    chk("pin_1234_d3", 64'(gen_q[3]), 64'({4'h1, 1'b0, 1'b0, 3'd3, 1'b0}));

    repeat (3) @(posedge clk);
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_outputs", 64'({out_nib, out_incr, out_neg, out_idx, out_last}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Directed operands under continuous ready.
    send(16'h0000); wait_idle();
    send(16'h00F8); wait_idle();
    send(16'hFFFF); wait_idle();

    // Stalled stream.
    send(16'h1234);
    k = 0;
    while (m_busy && k < 200) begin
      out_ready = pat[k % 4];
      k++;
      step();
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset while digit 2 is on the output.
    send(16'h8888);
    step();
    step();
    chk("mid_rst_idx", 64'(out_idx), 64'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    step();
    send(16'h0007); wait_idle();

    // in_valid held with changing in_b during RUN.
    send(16'hA5C3);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_b     = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_b      = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/nibble_recoder.md
Name: nibble_recoder

Overview:
- Sequential radix-16 signed-digit recoder; the stage directly upstream of the 4-bit increment circuit in the LUT multiplier datapath.
- Accepts one unsigned multiplier operand per transaction and streams one digit per accepted output beat.
- Each beat carries the raw nibble and the incoming carry, wired straight to the incrementer's A/incr inputs, plus the sign flag for the LUT/accumulate stage.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4, minimum 4.
- NDIG, WIDTH/4+1, digits emitted per operand (derived, do not override).
- IDXW, clog2(NDIG), width of the digit index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_b  input  WIDTH  unsigned multiplier operand.
- out_valid  output  1  digit beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_nib  output  4  raw nibble i of the operand; 0 on the final digit. Drives incrementer A.
- out_incr  output  1  carry-in c_i to this digit. Drives incrementer incr.
- out_neg  output  1  digit is negative: (out_nib+out_incr) >= 8.
- out_idx  output  IDXW  digit index i, 0..NDIG-1.
- out_last  output  1  final digit of the operand.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid, out_nib, out_incr, out_neg, out_idx and out_last all 0; operand register and carry cleared.
- Reset behaviour mid-operation: when rst is high during RUN, the in-flight operand is dropped with no further beats. On the next cycle the block is in IDLE with in_ready=1.
- States: IDLE and RUN.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid: capture in_b, set c=0 and i=0, go to RUN.
  - Digit 0 is presented registered on the next cycle (1-cycle latency from input accept to first out_valid).
- RUN:
  - in_ready=0; out_valid=1. Outputs are registered and held stable while out_valid and !out_ready.
  - For i < NDIG-1:
    - out_nib = b[4i+3:4i]
    - out_incr = c
    - out_neg = (out_nib + c >= 8), computed at 5-bit width so 15+1=16 is handled.
  - For i = NDIG-1:
    - out_nib=0, out_incr=c, out_neg=0, out_last=1.
  - On out_valid & out_ready, non-last beat: c <= out_neg, i <= i+1, and the next digit is presented the following cycle (one beat per cycle under continuous ready).
  - On out_valid & out_ready with out_last: return to IDLE, out_valid=0.
- Throughput: NDIG+1 cycles per operand under full ready, including the IDLE accept cycle. No overlap between operands.
- Arithmetic invariant: B = sum over i of (out_nib_i + out_incr_i - 16*out_neg_i) * 16^i. Each digit value lies in [-8, 7], and the final digit lies in {0, 1}.
- Boundaries:
  - Nibble F with incr=1 gives out_neg=1; the incrementer sees S=0, Co=1.
  - in_valid while in RUN is ignored and in_ready stays 0.
  - in_b is sampled only in the accept cycle.
  - The index does not wrap; i resets to 0 on every accept.

Decomposition:
- Shared package (lut_mult_pkg):
  - state enum {IDLE, RUN}
  - constant NIBW=4
  - constant NEG_THRESH=8
  - function ndig(width)
- Sub-module digit_sel: combinational nibble mux selecting b[4i+3:4i] (0 at the final index) and computing out_neg from nibble+carry.
- The FSM, counter and registers stay in nibble_recoder.

Test Plan:
- rst, then in_b=16'h0000 with out_ready=1 -> 5 beats, each with nib=0, incr=0, neg=0, idx=0..4; last=1 only on idx 4; in_ready=1 again on the following cycle.
- in_b=16'h00F8 -> (nib,incr,neg) = (8,0,1), (F,1,1), (0,1,0), (0,0,0), final (0,0,0). Reconstructed value = -8 + 0*16 + 1*256 = 248.
- in_b=16'hFFFF -> idx0 (F,0,1); idx1..3 (F,1,1); final (0,1,0) with last=1. Reconstructed value = 65535.
- in_b=16'h1234 with out_ready toggling 1,0,0,1,... -> outputs held stable during stalls; digit sequence identical to the no-stall run: (4,0,0), (3,0,0), (2,0,0), (1,0,0), (0,0,0).
- rst asserted during idx 2 of operand 16'h8888 -> next cycle out_valid=0 and in_ready=1. A new operand 16'h0007 then yields (7,0,0), (0,0,0)x3, and final (0,0,0).
- in_valid held high during RUN with in_b changing -> no effect on the current digit stream; the next operand is accepted only after the out_last beat is accepted.
